// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
// Shared definitions for the round-robin adder arbiter.
//   arb_state_t : result-holding FSM states (S_IDLE, S_HOLD)
//   DEF_N       : default operand/sum width
//   DEF_NUM_REQ : default number of requesters
// -----------------------------------------------------------------------------
package adder_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,  // no result held
        S_HOLD = 1'b1   // result held, rsp_valid asserted
    } arb_state_t;

    localparam int DEF_N       = 32;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/adder_n.sv
// -----------------------------------------------------------------------------
// adder_n
// N-bit adder with carry-in, unsigned carry-out and signed overflow flag.
//   i_a, i_b : operands
//   i_c_in   : carry-in
//   o_sum    : (i_a + i_b + i_c_in) mod 2^N
//   o_c_out  : unsigned carry out of bit N-1
//   o_ovf    : signed overflow (operand signs equal, sum sign differs)
// -----------------------------------------------------------------------------
module adder_n #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_c_in,
    output logic [N-1:0] o_sum,
    output logic         o_c_out,
    output logic         o_ovf
);

    logic [N:0] w_full;

    assign w_full  = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_c_in};
    assign o_sum   = w_full[N-1:0];
    assign o_c_out = w_full[N];
    assign o_ovf   = (i_a[N-1] == i_b[N-1]) && (w_full[N-1] != i_a[N-1]);

endmodule

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. Finds the first set bit of i_req,
// searching i_rr_ptr, i_rr_ptr+1, ... modulo NUM_REQ.
//   i_req    : request vector
//   i_rr_ptr : index with highest priority
//   o_any    : at least one request present
//   o_grant  : index of the selected request (0 when o_any=0)
// -----------------------------------------------------------------------------
module rr_pick
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic               o_any,
    output logic [ID_W-1:0]    o_grant
);

    logic [ID_W-1:0] w_idx;

    // Scan from the farthest offset down to offset 0 so the closest hit to
    // the pointer is the last assignment and therefore wins.
    always_comb begin
        o_any   = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = ID_W'((int'(i_rr_ptr) + off) % NUM_REQ);
            if (i_req[w_idx]) begin
                o_any   = 1'b1;
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
// Time-shares one adder_n between NUM_REQ requesters with round-robin
// priority. The result for an accepted request is registered and presented
// one cycle later, tagged with the requester index.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept, one-hot or zero
//   req_a/b    : packed operands, requester i at [i*N +: N]
//   req_c_in   : per-requester carry-in
//   rsp_valid  : result valid (state S_HOLD)
//   rsp_ready  : consumer accepts result
//   rsp_sum, rsp_c_out, rsp_ovf, rsp_id : registered result and its source
//   dbg_state  : current FSM state (arb_state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready never depends on the requester's own operand data, and
// rsp_* is held stable while rsp_valid=1 and rsp_ready=0.
// -----------------------------------------------------------------------------
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    input  logic [NUM_REQ-1:0]   req_c_in,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [N-1:0]         rsp_sum,
    output logic                 rsp_c_out,
    output logic                 rsp_ovf,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 dbg_state
);

    arb_state_t      r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [N-1:0]    r_op_a;
    logic [N-1:0]    r_op_b;
    logic            r_op_c;
    logic [ID_W-1:0] r_op_id;

    logic            w_any;
    logic [ID_W-1:0] w_grant;
    logic            w_can_accept;
    logic            w_accept;
    logic [N-1:0]    w_mux_a;
    logic [N-1:0]    w_mux_b;
    logic            w_mux_c;
    logic [N-1:0]    w_add_a;
    logic [N-1:0]    w_add_b;
    logic            w_add_c;
    logic [N-1:0]    w_sum;
    logic            w_c_out;
    logic            w_ovf;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req    (req_valid),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_grant  (w_grant)
    );

    // A held result that is being consumed this cycle frees the slot, which
    // is what allows one result per cycle back-to-back.
    assign w_can_accept = (r_state == S_IDLE) || rsp_ready;
    assign w_accept     = w_any && w_can_accept;

    always_comb begin
        req_ready = '0;
        w_mux_a   = '0;
        w_mux_b   = '0;
        w_mux_c   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                req_ready[i] = w_accept;
                w_mux_a      = req_a[i*N +: N];
                w_mux_b      = req_b[i*N +: N];
                w_mux_c      = req_c_in[i];
            end
        end
    end

    // The adder sees the request mux directly on an accepting cycle so the
    // result can be registered at the same edge as the operands.
    assign w_add_a = w_accept ? w_mux_a : r_op_a;
    assign w_add_b = w_accept ? w_mux_b : r_op_b;
    assign w_add_c = w_accept ? w_mux_c : r_op_c;

    adder_n #(
        .N (N)
    ) u_adder (
        .i_a     (w_add_a),
        .i_b     (w_add_b),
        .i_c_in  (w_add_c),
        .o_sum   (w_sum),
        .o_c_out (w_c_out),
        .o_ovf   (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_c    <= 1'b0;
            r_op_id   <= '0;
            rsp_sum   <= '0;
            rsp_c_out <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= '0;
        end else if (w_accept) begin
            r_state   <= S_HOLD;
            r_rr_ptr  <= (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + 1'b1;
            r_op_a    <= w_mux_a;
            r_op_b    <= w_mux_b;
            r_op_c    <= w_mux_c;
            r_op_id   <= w_grant;
            rsp_sum   <= w_sum;
            rsp_c_out <= w_c_out;
            rsp_ovf   <= w_ovf;
            rsp_id    <= w_grant;
        end else if (r_state == S_HOLD && rsp_ready) begin
            // Consumed with nothing new: data is retained, only valid drops.
            r_state <= S_IDLE;
        end
    end

    assign rsp_valid = (r_state == S_HOLD);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

  localparam int N  = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  // -------------------- clock / reset --------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*N-1:0] req_a     = '0;
  logic [NR*N-1:0] req_b     = '0;
  logic [NR-1:0]   req_c_in  = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [N-1:0]    rsp_sum;
  logic            rsp_c_out;
  logic            rsp_ovf;
  logic [IW-1:0]   rsp_id;
  logic            dbg_state;

  // {valid, id, c_out, ovf, sum}
  logic [36:0] obs;
  assign obs = {rsp_valid, rsp_id, rsp_c_out, rsp_ovf, rsp_sum};

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];

  adder_rr_arbiter #(.N(N), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c_in  (req_c_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_c_out (rsp_c_out),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id),
    .dbg_state (dbg_state)
  );

  // Hand-computed carry/overflow vectors
  localparam logic [31:0] CA  [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000,
                                      32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] CB  [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000,
                                      32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic        CC  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] CS  [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                      32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
  localparam logic        CCO [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic        COV [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // Requester i operands in the fairness test: a=100*i+1, b=16*i, c=i%2
  localparam logic [31:0] RR_SUM [4] = '{32'd1, 32'd118, 32'd233, 32'd350};

  // -------------------- driver tasks --------------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic c);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
    req_c_in[i]     = c;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    step;
    step;
    rst = 1'b1;
  endtask

  function automatic logic [36:0] exp_rsp(input logic [IW-1:0] id, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic c);
    logic [N:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
    v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    return {1'b1, id, s[N], v, s[N-1:0]};
  endfunction

  // -------------------- tests --------------------
  task automatic test_reset;
    #3;
    total++;
    if (obs !== 37'h0) begin
      bad++;
      $display("FAIL reset_rsp: got %h want %h", obs, 37'h0);
    end
    total++;
    if (dbg_state !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_state: got state=%b ready=%b want state=0 ready=0000",
               dbg_state, req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single;
    rsp_ready = 1'b0;
    set_req(0, 32'd5, 32'd7, 1'b0);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    step;
    total++;
    if (obs !== {1'b1, 2'd0, 1'b0, 1'b0, 32'd12} || dbg_state !== 1'b1) begin
      bad++;
      $display("FAIL single_rsp: got %h state=%b want %h state=1", obs, dbg_state,
               {1'b1, 2'd0, 1'b0, 1'b0, 32'd12});
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    step;
    total++;
    if (obs !== {1'b0, 2'd0, 1'b0, 1'b0, 32'd12}) begin
      bad++;
      $display("FAIL single_drain: got %h want %h", obs, {1'b0, 2'd0, 1'b0, 1'b0, 32'd12});
    end
  endtask

  task automatic test_carry_ovf;
    logic [1:0] id;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      id = 2'(k % 4);
      set_req(k % 4, CA[k], CB[k], CC[k]);
      req_valid = 4'b0001 << id;
      step;
      total++;
      if (obs !== {1'b1, id, CCO[k], COV[k], CS[k]}) begin
        bad++;
        $display("FAIL carry_ovf_%0d: got %h want %h", k, obs, {1'b1, id, CCO[k], COV[k], CS[k]});
      end
    end
    req_valid = 4'b0000;
    step;
  endtask

  task automatic test_round_robin;
    logic [1:0] id;
    do_reset;
    for (int i = 0; i < NR; i++) set_req(i, 32'(100 * i + 1), 32'(16 * i), 1'(i % 2));
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      id = 2'(k % 4);
      total++;
      if (req_ready !== (4'b0001 << id)) begin
        bad++;
        $display("FAIL rr_ready_%0d: got %b want %b", k, req_ready, 4'b0001 << id);
      end
      step;
      total++;
      if (obs !== {1'b1, id, 1'b0, 1'b0, RR_SUM[id]}) begin
        bad++;
        $display("FAIL rr_rsp_%0d: got %h want %h", k, obs, {1'b1, id, 1'b0, 1'b0, RR_SUM[id]});
      end
    end
    req_valid = 4'b0000;
    step;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain: got valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL bp_first_ready: got %b want 0010", req_ready);
    end
    step;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (req_ready !== 4'b0000 || obs !== {1'b1, 2'd1, 1'b0, 1'b0, 32'd118}) begin
        bad++;
        $display("FAIL bp_hold_%0d: got ready=%b rsp=%h want ready=0000 rsp=%h", k,
                 req_ready, obs, {1'b1, 2'd1, 1'b0, 1'b0, 32'd118});
      end
      step;
    end
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 0100", req_ready);
    end
    step;
    total++;
    if (obs !== {1'b1, 2'd2, 1'b0, 1'b0, 32'd233}) begin
      bad++;
      $display("FAIL bp_release_rsp: got %h want %h", obs, {1'b1, 2'd2, 1'b0, 1'b0, 32'd233});
    end
    req_valid = 4'b0000;
    step;
  endtask

  task automatic test_async_reset;
    rsp_ready = 1'b0;
    set_req(0, 32'h0000_1234, 32'h0000_1111, 1'b0);
    req_valid = 4'b0001;
    step;
    total++;
    if (obs !== {1'b1, 2'd0, 1'b0, 1'b0, 32'h2345}) begin
      bad++;
      $display("FAIL ar_hold: got %h want %h", obs, {1'b1, 2'd0, 1'b0, 1'b0, 32'h2345});
    end
    req_valid = 4'b0000;
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (obs !== 37'h0 || dbg_state !== 1'b0) begin
      bad++;
      $display("FAIL ar_clear: got %h state=%b want 0 state=0", obs, dbg_state);
    end
    step;
    step;
    rst = 1'b1;
    rsp_ready = 1'b1;
    set_req(3, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0);
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL ar_grant3_ready: got %b want 1000", req_ready);
    end
    step;
    total++;
    if (obs !== {1'b1, 2'd3, 1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL ar_grant3_rsp: got %h want %h", obs, {1'b1, 2'd3, 1'b1, 1'b0, 32'h0});
    end
    // Pointer wrapped to 0, so requester 0 beats requester 3.
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL ar_wrap_ready: got %b want 0001", req_ready);
    end
    step;
    total++;
    if (obs !== {1'b1, 2'd0, 1'b0, 1'b0, 32'h2345}) begin
      bad++;
      $display("FAIL ar_wrap_rsp: got %h want %h", obs, {1'b1, 2'd0, 1'b0, 1'b0, 32'h2345});
    end
    req_valid = 4'b0000;
    step;
  endtask

  task automatic test_random;
    logic [NR-1:0] pend;
    logic [N-1:0]  pa[NR];
    logic [N-1:0]  pb[NR];
    logic          pc[NR];
    int            waits[NR];
    int            m_ptr;
    logic          m_hold;
    logic          can;
    logic          found;
    int            g;
    int            idx;
    int            txn;
    int            cyc;
    logic [NR-1:0] exp_ready;
    logic [36:0]   e;
    do_reset;
    exp_q.delete();
    pend   = '0;
    m_ptr  = 0;
    m_hold = 1'b0;
    txn    = 0;
    cyc    = 0;
    for (int i = 0; i < NR; i++) waits[i] = 0;
    while (txn < 10000 && cyc < 60000) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pa[i]    = $urandom();
          pb[i]    = $urandom();
          pc[i]    = 1'($urandom_range(0, 1));
          waits[i] = 0;
          set_req(i, pa[i], pb[i], pc[i]);
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      can   = !m_hold || rsp_ready;
      found = 1'b0;
      g     = 0;
      for (int off = 0; off < NR; off++) begin
        idx = (m_ptr + off) % NR;
        if (!found && pend[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      exp_ready = (found && can) ? (4'b0001 << g) : 4'b0000;
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, req_ready, exp_ready);
      end
      if (m_hold && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rnd_rsp cyc=%0d: got %h want none queued", cyc, obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            bad++;
            $display("FAIL rnd_rsp cyc=%0d: got %h want %h", cyc, obs, e);
          end
        end
      end
      if (found && can) begin
        for (int i = 0; i < NR; i++) if (i != g && pend[i]) waits[i]++;
        total++;
        if (waits[g] > NR - 1) begin
          bad++;
          $display("FAIL rnd_starve id=%0d: got %0d accepts waited want <= %0d", g, waits[g], NR - 1);
        end
        waits[g] = 0;
        exp_q.push_back(exp_rsp(IW'(g), pa[g], pb[g], pc[g]));
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % NR;
        m_hold  = 1'b1;
        txn++;
      end else if (m_hold && rsp_ready) begin
        m_hold = 1'b0;
      end
      step;
      cyc++;
    end
    total++;
    if (txn < 10000) begin
      bad++;
      $display("FAIL rnd_budget: got %0d transactions want 10000", txn);
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    step;
  endtask

  // -------------------- sequence and report --------------------
  initial begin
    test_reset;
    test_single;
    test_carry_ovf;
    test_round_robin;
    test_backpressure;
    test_async_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
